// File: rtl/logarithm_pkg.sv
// Shared defaults and sample types for the per-filter log2 compressor.
// The LOG_ROUND_EN macro selects round-to-nearest mantissa handling in
// log2_lane; when it is undefined the mantissa is truncated.
package logarithm_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int LOG_WIDTH   = 8;
    localparam int FRAC_BITS   = 3;
    localparam int NUM_FILTERS = 26;

    // Floor for non-positive energies and ceiling for large ones.
    localparam int LOG_MIN = -(2 ** (LOG_WIDTH - 1));
    localparam int LOG_MAX = (2 ** (LOG_WIDTH - 1)) - 1;

    typedef logic signed [DATA_WIDTH-1:0] mel_t;
    typedef logic signed [LOG_WIDTH-1:0]  log_t;

endpackage

// File: rtl/log2_lane.sv
// One combinational log2 lane: leading-one detect, mantissa extraction
// below the leading one, optional round-to-nearest (LOG_ROUND_EN),
// saturation to the positive maximum, and a floor for x <= 0.
module log2_lane
    import logarithm_pkg::*;
#(
    parameter int DATA_WIDTH = logarithm_pkg::DATA_WIDTH,
    parameter int LOG_WIDTH  = logarithm_pkg::LOG_WIDTH,
    parameter int FRAC_BITS  = logarithm_pkg::FRAC_BITS
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic signed [LOG_WIDTH-1:0]  l
);

    localparam int KW = $clog2(DATA_WIDTH);
    localparam logic [31:0] LMAX = (32'd1 << (LOG_WIDTH - 1)) - 32'd1;

`ifdef LOG_ROUND_EN
    // One extra bit below the mantissa field carries the rounding decision.
    localparam int EW = DATA_WIDTH + FRAC_BITS + 1;
    localparam int FW = FRAC_BITS + 1;
`else
    localparam int EW = DATA_WIDTH + FRAC_BITS;
    localparam int FW = FRAC_BITS;
`endif

    logic [KW-1:0] k;
    logic [EW-1:0] ext;
    logic [FW-1:0] field;
    logic [31:0]   val;
    logic          non_pos;

    // Leading-one position; the sign bit is excluded since x > 0 when used.
    always_comb begin
        k = '0;
        for (int b = 0; b < DATA_WIDTH - 1; b++) begin
            if (x[b]) k = KW'(b);
        end
    end

    // Mantissa bits just below the leading one, zero-padded at the bottom,
    // then the fixed-point sum k*2^FRAC_BITS + f (a rounding carry
    // naturally propagates into the integer part).
    always_comb begin
        ext     = {x, {(EW - DATA_WIDTH){1'b0}}};
        field   = FW'(ext >> k);
        non_pos = x[DATA_WIDTH-1] || (x == '0);
`ifdef LOG_ROUND_EN
        val = (32'(k) << FRAC_BITS) + ((32'(field) + 32'd1) >> 1);
`else
        val = (32'(k) << FRAC_BITS) + 32'(field);
`endif
        if (non_pos) begin
            l = {1'b1, {(LOG_WIDTH - 1){1'b0}}};
        end else if (val > LMAX) begin
            l = LMAX[LOG_WIDTH-1:0];
        end else begin
            l = val[LOG_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/logarithm.sv
// Parallel log2 compressor between the mel filterbank and the DCT.
// Results pass through combinationally while mel_valid is high; a hold
// register per lane keeps the last valid result visible otherwise.
// Optional macro: LOG_ROUND_EN (round-to-nearest mantissa in each lane).
module logarithm
    import logarithm_pkg::*;
#(
    parameter int DATA_WIDTH  = logarithm_pkg::DATA_WIDTH,
    parameter int LOG_WIDTH   = logarithm_pkg::LOG_WIDTH,
    parameter int NUM_FILTERS = logarithm_pkg::NUM_FILTERS,
    parameter int FRAC_BITS   = logarithm_pkg::FRAC_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATA_WIDTH-1:0] mel_in [0:NUM_FILTERS-1],
    input  logic                        mel_valid,
    output logic signed [LOG_WIDTH-1:0]  log_out [0:NUM_FILTERS-1],
    output logic                        log_valid
);

    logic signed [LOG_WIDTH-1:0] lane_l   [0:NUM_FILTERS-1];
    logic signed [LOG_WIDTH-1:0] hold_reg [0:NUM_FILTERS-1];

    // Valid is suppressed while reset is asserted.
    assign log_valid = mel_valid & ~rst;

    generate
        for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_lane
            log2_lane #(
                .DATA_WIDTH(DATA_WIDTH),
                .LOG_WIDTH (LOG_WIDTH),
                .FRAC_BITS (FRAC_BITS)
            ) u_lane (
                .x(mel_in[gi]),
                .l(lane_l[gi])
            );

            // Capture the lane result on valid cycles; reset has priority.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_reg[gi] <= '0;
                end else if (mel_valid) begin
                    hold_reg[gi] <= lane_l[gi];
                end
            end

            assign log_out[gi] = mel_valid ? lane_l[gi] : hold_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_logarithm.sv
// Scoreboard bench for logarithm: the stimulus process pushes the expected
// output of every cycle; a monitor pops and compares on the falling edge.
module tb_logarithm;

    localparam int DW = 16;
    localparam int LW = 8;
    localparam int NF = 26;

    typedef struct packed {
        logic          v;
        logic [NF*LW-1:0] o;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mel_valid;
    logic signed [DW-1:0] mel_in  [0:NF-1];
    logic signed [LW-1:0] log_out [0:NF-1];
    logic                 log_valid;

    exp_t q[$];
    int   held [0:NF-1];
    int   total  = 0;
    int   passed = 0;
    bit   done   = 1'b0;

    logarithm dut (
        .clk      (clk),
        .rst      (rst),
        .mel_in   (mel_in),
        .mel_valid(mel_valid),
        .log_out  (log_out),
        .log_valid(log_valid)
    );

    always #5 clk = ~clk;

    // Reference log2: leading-one exponent by powers of two, mantissa from
    // the scaled quotient (which includes the implicit leading one).
    function automatic int ref_l(int x);
        int k, q, l;
        if (x <= 0) return -128;
        k = 0;
        while ((2 ** (k + 1)) <= x) k++;
`ifdef LOG_ROUND_EN
        q = (x * 16) / (2 ** k);
        q = (q + 1) / 2;
`else
        q = (x * 8) / (2 ** k);
`endif
        l = k * 8 + q - 8;
        if (l > 127) l = 127;
        return l;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Apply one cycle of stimulus and record what the DUT must show.
    task automatic drive(input bit v, input bit r, input int vals [0:NF-1]);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        mel_valid = v;
        for (int i = 0; i < NF; i++) mel_in[i] = DW'(vals[i]);
        e.v = v & ~r;
        for (int i = 0; i < NF; i++)
            e.o[i*LW +: LW] = LW'(v ? ref_l(vals[i]) : held[i]);
        q.push_back(e);
        for (int i = 0; i < NF; i++) begin
            if (r) held[i] = 0;
            else if (v) held[i] = ref_l(vals[i]);
        end
    endtask

    // Monitor: compare every cycle's outputs against the scoreboard.
    initial begin
        exp_t e;
        logic [NF*LW-1:0] act;
        int n = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < NF; i++) act[i*LW +: LW] = log_out[i];
                total++;
                if (log_valid === e.v && act === e.o) begin
                    passed++;
                    $display("txn %0d: valid=%0b lane0=%0d lane25=%0d ok",
                             n, log_valid, log_out[0], log_out[NF-1]);
                end else begin
                    $display("FAIL txn %0d: got valid=%0b lane0=%0d lane25=%0d expected valid=%0b lane0=%0d lane25=%0d",
                             n, log_valid, log_out[0], log_out[NF-1], e.v,
                             $signed(e.o[0 +: LW]), $signed(e.o[(NF-1)*LW +: LW]));
                end
                n++;
                chk("protocol", int'(log_valid & ~mel_valid), 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v [0:NF-1];
        int sel;
        rst = 1'b1;
        mel_valid = 1'b0;
        for (int i = 0; i < NF; i++) begin
            mel_in[i] = '0;
            held[i] = 0;
        end
        repeat (2) @(posedge clk);

        // Reset state: nothing valid, all zero.
        for (int i = 0; i < NF; i++) v[i] = 0;
        drive(0, 0, v);
        @(negedge clk);
        chk("reset_valid", int'(log_valid), 0);
        chk("reset_out0", int'(log_out[0]), 0);
        chk("reset_out25", int'(log_out[NF-1]), 0);

        // Ramp.
        for (int i = 0; i < NF; i++) v[i] = i + 1;
        drive(1, 0, v);
        @(negedge clk);
        chk("ramp_valid", int'(log_valid), 1);
        chk("ramp_0", int'(log_out[0]), 0);
        chk("ramp_1", int'(log_out[1]), 8);
        chk("ramp_2", int'(log_out[2]), 12);
        chk("ramp_3", int'(log_out[3]), 16);
        chk("ramp_7", int'(log_out[7]), 24);
        chk("ramp_25", int'(log_out[25]), 37);
        for (int i = 0; i < NF; i++) v[i] = 0;
        drive(0, 0, v);
        @(negedge clk);
        chk("hold_valid", int'(log_valid), 0);
        chk("hold_25", int'(log_out[25]), 37);

        // Zero and negative inputs.
        drive(1, 0, v);
        @(negedge clk);
        chk("zero_5", int'(log_out[5]), -128);
        for (int i = 0; i < NF; i++) v[i] = -i;
        drive(1, 0, v);
        @(negedge clk);
        chk("neg_10", int'(log_out[10]), -128);

        // Large inputs.
        for (int i = 0; i < NF; i++) v[i] = 1000 + i;
        drive(1, 0, v);
        @(negedge clk);
`ifdef LOG_ROUND_EN
        chk("large_0", int'(log_out[0]), 80);
`else
        chk("large_0", int'(log_out[0]), 79);
`endif
        chk("large_25", int'(log_out[25]), 80);
        for (int i = 0; i < NF; i++) v[i] = 32767;
        drive(1, 0, v);
        @(negedge clk);
`ifdef LOG_ROUND_EN
        chk("max_0", int'(log_out[0]), 120);
`else
        chk("max_0", int'(log_out[0]), 119);
`endif

        // Collision: reset beats capture.
        for (int i = 0; i < NF; i++) v[i] = i + 1;
        drive(1, 1, v);
        @(negedge clk);
        chk("coll_valid", int'(log_valid), 0);
        drive(0, 0, v);
        @(negedge clk);
        chk("coll_hold", int'(log_out[3]), 0);

        // Randomized traffic.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NF; i++) begin
                sel = int'($urandom_range(0, 3));
                case (sel)
                    0: v[i] = int'($urandom_range(0, 15));
                    1: v[i] = int'($urandom_range(0, 32767));
                    2: v[i] = -int'($urandom_range(0, 32768));
                    default: v[i] = 1 << $urandom_range(0, 14);
                endcase
            end
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), v);
        end
        for (int i = 0; i < NF; i++) v[i] = 0;
        drive(0, 0, v);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/logarithm.md
Name: logarithm

Overview:
- Per-filter base-2 log compressor for the MFCC front end; sits between the mel filterbank and the DCT.
- Converts NUM_FILTERS signed mel energies to signed fixed-point log2 values in parallel.
- Zero-latency combinational datapath; a hold register keeps the last result visible between valid cycles.

Parameters:
- DATA_WIDTH, 16, width of each signed mel input sample.
- LOG_WIDTH, 8, width of each signed log output in two's complement fixed point.
- NUM_FILTERS, 26, number of mel channels, processed in parallel lanes.
- FRAC_BITS, 3, fractional bits of the output; output = log2(x) * 2^FRAC_BITS.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- mel_in, input, array [0:NUM_FILTERS-1] of signed DATA_WIDTH, mel energies.
- mel_valid, input, 1, mel_in is valid this cycle.
- log_out, output, array [0:NUM_FILTERS-1] of signed LOG_WIDTH, log2 results.
- log_valid, output, 1, log_out is valid this cycle.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- log_valid = mel_valid & ~rst, combinational, with zero latency. log_valid is never high while mel_valid is low.
- Per lane, with x = mel_in[i], compute L(x):
  - x <= 0: L = -2^(LOG_WIDTH-1), i.e. -128 at the defaults. This is the log-of-zero floor.
  - x > 0: let k = index of the leading one (0..DATA_WIDTH-2).
  - Let f = the FRAC_BITS bits immediately below the leading one, zero-padded when k < FRAC_BITS.
  - L = k*2^FRAC_BITS + f. This is a linear-mantissa approximation of log2, truncated.
  - If L > 2^(LOG_WIDTH-1)-1, saturate to that maximum. At the defaults the maximum is 14*8+7 = 119, so no saturation occurs.
- log_out[i]:
  - When mel_valid = 1: log_out[i] is L(mel_in[i]) combinationally.
  - When mel_valid = 0: log_out[i] shows the held register.
- Hold register: on each rising edge with mel_valid = 1 and rst = 0, it captures L for every lane.
- Reset: on a rising edge with rst = 1, all hold registers clear to 0. While rst = 1, log_valid = 0.
- If rst and mel_valid are high on the same edge, reset wins and nothing is captured.
- All lanes are independent and identical. Every output is always within [-2^(LOG_WIDTH-1), 2^(LOG_WIDTH-1)-1].

Optional Feature:
- Macro: LOG_ROUND_EN.
- Defined: f is rounded to nearest using the next bit below the FRAC_BITS field. A carry out of f increments k. The result is then saturated to the maximum.
- Not defined: truncation, as described in Behaviour.
- x <= 0 handling is identical in both builds.

Decomposition:
- Package logarithm_pkg holds:
  - default widths DATA_WIDTH, LOG_WIDTH, FRAC_BITS, NUM_FILTERS;
  - LOG_MIN and LOG_MAX constants;
  - typedefs for the mel sample and log sample.
- Sub-module log2_lane: combinational leading-one detector plus mantissa extraction, saturation and optional rounding for one sample.
- logarithm instantiates NUM_FILTERS log2_lane copies in a generate loop and owns the hold registers and valid logic.

Test Plan:
- Reset: rst = 1 for 2 cycles, then deassert with mel_valid = 0 -> log_valid = 0 and all log_out = 0.
- Ramp: mel_in[i] = i+1 with a 1-cycle mel_valid -> in that cycle log_valid = 1 and:
  - log_out[0] = 0, [1] = 8, [2] = 12, [3] = 16, [7] = 24, [25] = 37.
  - Next cycle: log_valid = 0 and the same values are held.
- Zero and negative: mel_in all 0, then mel_in[i] = -i -> every log_out = -128 while valid.
- Large: mel_in[i] = 1000+i -> log_out[0] = 79 (truncated; 80 with LOG_ROUND_EN), log_out[25] = 80. Check mel_in = 32767 -> 119.
- Protocol: throughout the run, assert that log_valid implies mel_valid and that every output is in [-128, 127].
- Collision: rst and mel_valid high on the same edge -> the hold register stays 0.
